// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bundle between the multi-cycle MIPS control FSM and its datapath
//   master (controller): op, zero and mem_ready are inputs; every datapath mux/enable plus
//                        illegal_op and fault are outputs
//   slave  (datapath)  : the mirror image of master
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
);
    logic [OPCODE_W-1:0] op;
    logic                zero;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic [1:0]          pc_source;
    logic                illegal_op;
    logic                fault;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, fault
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, fault
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle MIPS datapath with memory-wait timeout
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; all outputs read 0 while it is low
//   ctrl  : multicycle_control_if.master (op/zero/mem_ready in, datapath controls,
//           illegal_op pulse and sticky fault out)
//   Define CTRL_IMM_OPS_EN to add addi/andi/ori through the IEXEC/IWB states.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master ctrl
);
    localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(43);
`ifdef CTRL_IMM_OPS_EN
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(13);
`endif

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, HALT
`ifdef CTRL_IMM_OPS_EN
        , IEXEC, IWB
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                fault_q, fault_d;
    logic                waiting, timeout, legal;

    assign waiting = state_q inside {FETCH, MEMRD, MEMWR};
    // mem_ready on the last allowed cycle still wins over the timeout
    assign timeout = waiting && !ctrl.mem_ready && wait_q == WAIT_W'(MAX_WAIT);
    assign legal   = ctrl.op inside {OP_R, OP_J, OP_BEQ, OP_LW, OP_SW
`ifdef CTRL_IMM_OPS_EN
                                     , OP_ADDI, OP_ANDI, OP_ORI
`endif
                                    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = ctrl.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef CTRL_IMM_OPS_EN
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = IEXEC;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = ctrl.op == OP_LW ? MEMRD : ctrl.op == OP_SW ? MEMWR : FETCH;
            MEMRD:  state_d = ctrl.mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_d = ctrl.mem_ready ? FETCH : MEMWR;
            EXEC:   state_d = RWB;
`ifdef CTRL_IMM_OPS_EN
            IEXEC:  state_d = IWB;
            IWB:    state_d = FETCH;
`endif
            MEMWB, RWB, BRANCH, JUMP: state_d = FETCH;
            default: state_d = state_q;
        endcase
        if (timeout) state_d = HALT;
        // any state change clears the counter, which covers entry to every waiting state
        wait_d  = state_d != state_q ? '0 :
                  (waiting && !ctrl.mem_ready && wait_q != WAIT_W'(MAX_WAIT)) ? wait_q + 1'b1 : wait_q;
        fault_d = fault_q | timeout;
    end

    always_comb begin
        ctrl.pc_write      = 1'b0;
        ctrl.pc_write_cond = 1'b0;
        ctrl.iord          = 1'b0;
        ctrl.mem_read      = 1'b0;
        ctrl.mem_write     = 1'b0;
        ctrl.ir_write      = 1'b0;
        ctrl.mem_to_reg    = 1'b0;
        ctrl.reg_dst       = 1'b0;
        ctrl.reg_write     = 1'b0;
        ctrl.alu_src_a     = 1'b0;
        ctrl.alu_src_b     = 2'b00;
        ctrl.alu_op        = '0;
        ctrl.pc_source     = 2'b00;
        ctrl.illegal_op    = 1'b0;
        ctrl.fault         = fault_q;
        // gating on rst_n keeps the FETCH decode of the reset state off the bus during reset
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = 2'b01;
                    ctrl.ir_write  = ctrl.mem_ready;
                    ctrl.pc_write  = ctrl.mem_ready;
                end
                DECODE: begin
                    ctrl.alu_src_b  = 2'b11;
                    ctrl.illegal_op = !legal;
                end
                MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b10;
                end
                MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_op    = ALUOP_W'(2);
                end
                RWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALUOP_W'(1);
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = 2'b01;
                end
                JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = 2'b10;
                end
`ifdef CTRL_IMM_OPS_EN
                IEXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b10;
                    ctrl.alu_op    = ctrl.op == OP_ADDI ? ALUOP_W'(0) : ALUOP_W'(3);
                end
                IWB: ctrl.reg_write = 1'b1;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multi-cycle MIPS control FSM
module tb_multicycle_control;
    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
    //  reg_write, alu_src_a}_{alu_src_b}_{alu_op}_{pc_source}_{illegal_op}_{fault}
    localparam logic [17:0] O_ZERO     = 18'b0000000000_00_00_00_0_0;
    localparam logic [17:0] O_FETCH_R  = 18'b1001010000_01_00_00_0_0;
    localparam logic [17:0] O_FETCH_W  = 18'b0001000000_01_00_00_0_0;
    localparam logic [17:0] O_DECODE   = 18'b0000000000_11_00_00_0_0;
    localparam logic [17:0] O_DEC_ILL  = 18'b0000000000_11_00_00_1_0;
    localparam logic [17:0] O_MEMADR   = 18'b0000000001_10_00_00_0_0;
    localparam logic [17:0] O_MEMRD    = 18'b0011000000_00_00_00_0_0;
    localparam logic [17:0] O_MEMWB    = 18'b0000001010_00_00_00_0_0;
    localparam logic [17:0] O_MEMWR    = 18'b0010100000_00_00_00_0_0;
    localparam logic [17:0] O_EXEC     = 18'b0000000001_00_10_00_0_0;
    localparam logic [17:0] O_RWB      = 18'b0000000110_00_00_00_0_0;
    localparam logic [17:0] O_BRANCH   = 18'b0100000001_00_01_01_0_0;
    localparam logic [17:0] O_JUMP     = 18'b1000000000_00_00_10_0_0;
    localparam logic [17:0] O_HALT     = 18'b0000000000_00_00_00_0_1;
`ifdef CTRL_IMM_OPS_EN
    localparam logic [17:0] O_IEXEC_A  = 18'b0000000001_10_00_00_0_0;
    localparam logic [17:0] O_IEXEC_L  = 18'b0000000001_10_11_00_0_0;
    localparam logic [17:0] O_IWB      = 18'b0000000010_00_00_00_0_0;
`endif

    logic        clk;
    logic        rst_n;
    int          n_cmp;
    int          n_err;
    logic [17:0] outs;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    assign outs = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                   bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                   bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op, bus.fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        bus.op = 6'd35;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (outs !== O_ZERO) begin
                n_err++;
                $display("FAIL reset hold %0d: got %b want %b", i, outs, O_ZERO);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_FETCH_W) begin
            n_err++;
            $display("FAIL reset release: got %b want %b", outs, O_FETCH_W);
        end
    endtask

    task automatic test_lw();
        logic [17:0] e [5];
        e = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMRD, O_MEMWB};
        bus.op = 6'd35;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (outs !== e[i]) begin
                n_err++;
                $display("FAIL lw step %0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [17:0] e [7];
        logic        r [7];
        e = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMWR, O_MEMWR, O_MEMWR, O_MEMWR};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.op = 6'd43;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.mem_ready = r[i];
            #1;
            n_cmp++;
            if (outs !== e[i]) begin
                n_err++;
                $display("FAIL sw step %0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_short_ops();
        logic [17:0] e [10];
        logic [5:0]  o [10];
        e = '{O_FETCH_R, O_DECODE, O_BRANCH,
              O_FETCH_R, O_DECODE, O_EXEC, O_RWB,
              O_FETCH_R, O_DECODE, O_JUMP};
        o = '{6'd4, 6'd4, 6'd4, 6'd0, 6'd0, 6'd0, 6'd0, 6'd2, 6'd2, 6'd2};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.op = o[i];
            bus.mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (outs !== e[i]) begin
                n_err++;
                $display("FAIL beq/rtype/j step %0d op %0d: got %b want %b", i, o[i], outs, e[i]);
            end
        end
    endtask

    task automatic test_wait_boundary();
        logic [17:0] e;
        bus.op = 6'd35;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.mem_ready = !(i >= 3 && i <= 17);
            e = i == 0 ? O_FETCH_R : i == 1 ? O_DECODE : i == 2 ? O_MEMADR :
                i == 19 ? O_MEMWB : O_MEMRD;
            #1;
            n_cmp++;
            if (outs !== e) begin
                n_err++;
                $display("FAIL wait boundary step %0d: got %b want %b", i, outs, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [17:0] e;
        bus.op = 6'd35;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.mem_ready = i >= 17;
            e = i < 16 ? O_FETCH_W : O_HALT;
            #1;
            n_cmp++;
            if (outs !== e) begin
                n_err++;
                $display("FAIL timeout step %0d: got %b want %b", i, outs, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [17:0] e [4];
        e = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMRD};
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_ZERO) begin
            n_err++;
            $display("FAIL halt clear: got %b want %b", outs, O_ZERO);
        end
        bus.op = 6'd35;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            bus.mem_ready = i < 3;
            #1;
            n_cmp++;
            if (outs !== e[i]) begin
                n_err++;
                $display("FAIL abort setup step %0d: got %b want %b", i, outs, e[i]);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_ZERO) begin
            n_err++;
            $display("FAIL async abort: got %b want %b", outs, O_ZERO);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (outs !== O_ZERO) begin
            n_err++;
            $display("FAIL abort hold: got %b want %b", outs, O_ZERO);
        end
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_FETCH_W) begin
            n_err++;
            $display("FAIL abort release: got %b want %b", outs, O_FETCH_W);
        end
    endtask

    task automatic test_illegal();
        logic [17:0] e [3];
        e = '{O_FETCH_R, O_DEC_ILL, O_FETCH_W};
        bus.op = 6'd63;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ready = i < 2;
            #1;
            n_cmp++;
            if (outs !== e[i]) begin
                n_err++;
                $display("FAIL illegal step %0d: got %b want %b", i, outs, e[i]);
            end
        end
    endtask

    task automatic test_imm();
`ifdef CTRL_IMM_OPS_EN
        logic [17:0] e [8];
        logic [5:0]  o [8];
        e = '{O_FETCH_R, O_DECODE, O_IEXEC_A, O_IWB, O_FETCH_R, O_DECODE, O_IEXEC_L, O_IWB};
        o = '{6'd8, 6'd8, 6'd8, 6'd8, 6'd12, 6'd12, 6'd12, 6'd12};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.op = o[i];
            bus.mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (outs !== e[i]) begin
                n_err++;
                $display("FAIL imm step %0d op %0d: got %b want %b", i, o[i], outs, e[i]);
            end
        end
`else
        logic [17:0] e [3];
        e = '{O_FETCH_R, O_DEC_ILL, O_FETCH_W};
        bus.op = 6'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ready = i < 2;
            #1;
            n_cmp++;
            if (outs !== e[i]) begin
                n_err++;
                $display("FAIL addi illegal step %0d: got %b want %b", i, outs, e[i]);
            end
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_lw();
        test_sw();
        test_short_ops();
        test_wait_boundary();
        test_timeout();
        test_abort();
        test_illegal();
        test_imm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
